gpio_responder: RTL and testbench

Memory-mapped GPIO peripheral that answers the data bus on the GPIO side of the bus interconnect. It takes the shared address and write data, is written only when we_gpio is high, and returns registered read data on rdata_gpio. It drives pin output and output-enable vectors, synchronises pin inputs, and latches rising edges into a sticky status register.

---
 rtl/gpio_responder.sv | 124 ++++++++++++
 tb/tb_gpio_responder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/gpio_responder.sv
// Memory-mapped GPIO peripheral: output/direction registers, synchronised inputs, sticky rising-edge status.
// Optional IRQ_MASK register and irq output enabled by defining GPIO_IRQ_EN.
module gpio_responder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned PINS  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             we_gpio,
    output logic [WIDTH-1:0] rdata_gpio,
    input  logic [PINS-1:0]  gpio_in,
    output logic [PINS-1:0]  gpio_out,
    output logic [PINS-1:0]  gpio_oe,
    output logic             irq
);

    localparam int unsigned IDX_W = 3;

    localparam logic [IDX_W-1:0] IDX_DATA_OUT   = 3'd0;
    localparam logic [IDX_W-1:0] IDX_DIR        = 3'd1;
    localparam logic [IDX_W-1:0] IDX_DATA_IN    = 3'd2;
    localparam logic [IDX_W-1:0] IDX_IRQ_STATUS = 3'd3;
    localparam logic [IDX_W-1:0] IDX_IRQ_MASK   = 3'd4;

    logic [IDX_W-1:0] idx;
    logic [PINS-1:0]  wr_bits;
    logic [PINS-1:0]  data_out;
    logic [PINS-1:0]  dir;
    logic [PINS-1:0]  irq_status;
    logic [PINS-1:0]  sync1;
    logic [PINS-1:0]  sync2;
    logic [PINS-1:0]  prev;
    logic [PINS-1:0]  rise;
    logic [PINS-1:0]  clear;
    logic [PINS-1:0]  rd_c;
    logic             unused_ok;

    assign idx     = addr[4:2];
    assign wr_bits = wdata[PINS-1:0];

    // Only addr[4:2] and the low PINS bits of wdata carry meaning.
    assign unused_ok = ^{addr, wdata};

    // Control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
            dir      <= '0;
        end else if (we_gpio) begin
            if (idx == IDX_DATA_OUT) data_out <= wr_bits;
            if (idx == IDX_DIR)      dir      <= wr_bits;
        end
    end

    // Two-flop synchroniser plus previous-value flop for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= gpio_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise  = sync2 & ~prev;
    assign clear = (we_gpio && idx == IDX_IRQ_STATUS) ? wr_bits : '0;

    // Sticky status: write-1-to-clear, a simultaneous rise wins over the clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_status <= '0;
        end else begin
            irq_status <= (irq_status & ~clear) | rise;
        end
    end

`ifdef GPIO_IRQ_EN
    logic [PINS-1:0] irq_mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_mask <= '0;
        end else if (we_gpio && idx == IDX_IRQ_MASK) begin
            irq_mask <= wr_bits;
        end
    end

    assign irq = |(irq_status & irq_mask);
`else
    assign irq = 1'b0;
`endif

    // Read select; reserved indices return zero
    always_comb begin
        rd_c = '0;
        case (idx)
            IDX_DATA_OUT:   rd_c = data_out;
            IDX_DIR:        rd_c = dir;
            IDX_DATA_IN:    rd_c = sync2;
            IDX_IRQ_STATUS: rd_c = irq_status;
`ifdef GPIO_IRQ_EN
            IDX_IRQ_MASK:   rd_c = irq_mask;
`endif
            default:        rd_c = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_gpio <= '0;
        end else begin
            rdata_gpio <= WIDTH'(rd_c);
        end
    end

    assign gpio_out = data_out;
    assign gpio_oe  = dir;

endmodule

// File: tb/tb_gpio_responder.sv
// Directed self-checking bench for gpio_responder; read expectations flow through a scoreboard queue.
module tb_gpio_responder;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned PINS  = 8;

`ifdef GPIO_IRQ_EN
    localparam bit HAS_MASK = 1'b1;
`else
    localparam bit HAS_MASK = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
    logic             we_gpio;
    logic [WIDTH-1:0] rdata_gpio;
    logic [PINS-1:0]  gpio_in;
    logic [PINS-1:0]  gpio_out;
    logic [PINS-1:0]  gpio_oe;
    logic             irq;

    int n_cmp;
    int n_err;
    logic [WIDTH-1:0] exp_q[$];

    gpio_responder #(.WIDTH(WIDTH), .PINS(PINS)) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .wdata      (wdata),
        .we_gpio    (we_gpio),
        .rdata_gpio (rdata_gpio),
        .gpio_in    (gpio_in),
        .gpio_out   (gpio_out),
        .gpio_oe    (gpio_oe),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int unsigned ix, input logic [WIDTH-1:0] d);
        addr    = WIDTH'(ix << 2);
        wdata   = d;
        we_gpio = 1'b1;
        tick();
        we_gpio = 1'b0;
        wdata   = '0;
    endtask

    // Read with scoreboard: expectation queued at issue, popped after the capturing edge
    task automatic rd(input string tag, input int unsigned ix, input logic [WIDTH-1:0] exp);
        logic [WIDTH-1:0] e;
        addr    = WIDTH'(ix << 2) | 32'hFFFF_FF03;
        we_gpio = 1'b0;
        exp_q.push_back(exp);
        tick();
        e = exp_q.pop_front();
        chk(tag, rdata_gpio, e);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst     = 1'b1;
        addr    = '0;
        wdata   = '0;
        we_gpio = 1'b0;
        gpio_in = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_gpio_out", WIDTH'(gpio_out), '0);
        chk("rst_gpio_oe",  WIDTH'(gpio_oe),  '0);
        chk("rst_irq",      WIDTH'(irq),      '0);
        for (int i = 0; i < 8; i++) rd($sformatf("rst_rd%0d", i), i, '0);

        // Output and direction registers
        wr(0, 32'hFFFF_FFA5);
        chk("gpio_out_a5", WIDTH'(gpio_out), 32'h0000_00A5);
        wr(1, 32'h0000_000F);
        chk("gpio_oe_0f", WIDTH'(gpio_oe), 32'h0000_000F);
        rd("rd_data_out", 0, 32'h0000_00A5);
        rd("rd_dir", 1, 32'h0000_000F);
        addr = '0; wdata = 32'h0000_0033; we_gpio = 1'b0;
        tick();
        chk("no_we_out", WIDTH'(gpio_out), 32'h0000_00A5);

        // Read and write same address in one cycle returns the old value
        addr = '0; wdata = 32'h0000_0011; we_gpio = 1'b1;
        exp_q.push_back(32'h0000_00A5);
        tick();
        we_gpio = 1'b0;
        chk("rd_wr_old", rdata_gpio, exp_q.pop_front());
        rd("rd_wr_new", 0, 32'h0000_0011);
        rd("reserved7", 7, '0);

        // Input synchroniser and rising-edge status
        gpio_in = 8'h81;
        tick();
        tick();
        rd("data_in_81", 2, 32'h0000_0081);
        rd("status_81", 3, 32'h0000_0081);
        gpio_in = 8'h00;
        tick(); tick(); tick();
        rd("status_sticky", 3, 32'h0000_0081);
        rd("data_in_00", 2, '0);

        // Write-1-to-clear, and set wins over a simultaneous clear
        wr(3, 32'h0000_0001);
        rd("status_clr0", 3, 32'h0000_0080);
        gpio_in = 8'h80;
        tick();
        tick();
        wr(3, 32'h0000_0080);
        rd("status_set_wins", 3, 32'h0000_0080);
        wr(3, 32'h0000_0080);
        rd("status_clr7", 3, '0);

        // Interrupt masking
        wr(4, 32'h0000_0080);
        gpio_in = 8'h00;
        tick(); tick(); tick();
        gpio_in = 8'h81;
        tick(); tick(); tick();
        rd("status_81b", 3, 32'h0000_0081);
        rd("irq_mask_rd", 4, HAS_MASK ? 32'h0000_0080 : 32'h0);
        chk("irq_on", WIDTH'(irq), WIDTH'(HAS_MASK));
        wr(3, 32'h0000_0080);
        chk("irq_off", WIDTH'(irq), '0);
        rd("status_01", 3, 32'h0000_0001);

        // Asynchronous reset in the middle of a write
        gpio_in = 8'h01;
        addr = '0; wdata = 32'h0000_0055; we_gpio = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_gpio_out", WIDTH'(gpio_out), '0);
        chk("arst_gpio_oe",  WIDTH'(gpio_oe),  '0);
        chk("arst_irq",      WIDTH'(irq),      '0);
        chk("arst_rdata",    rdata_gpio,       '0);
        we_gpio = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        rd("post_rst_out", 0, '0);
        rd("post_rst_dir", 1, '0);
        rd("post_rst_st_early", 3, '0);
        rd("post_rst_st_set", 3, 32'h0000_0001);
        chk("post_rst_gpio_out", WIDTH'(gpio_out), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
